// File: rtl/prpg_bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// prpg_bist_ctrl_if
//
// Purpose: groups the test-control and CUT-facing signals of the PRPG BIST
// sequencer into one bundle. Clock and reset stay outside as plain ports.
//
// Signal summary:
//   start         control -> BIST  begin a test (honoured only when idle)
//   seed          control -> BIST  PRPG seed
//   num_pat       control -> BIST  number of patterns to apply
//   golden        control -> BIST  expected final signature
//   response      CUT     -> BIST  CUT output for the current pattern
//   pattern       BIST    -> CUT   current PRPG state
//   pattern_valid BIST    -> CUT   pattern is being applied this cycle
//   busy          BIST    -> ctrl  a test is in progress
//   done          BIST    -> ctrl  one-cycle end-of-test pulse
//   pass          BIST    -> ctrl  last signature matched golden
//   seed_err      BIST    -> ctrl  last seed was all-zero
//   signature     BIST    -> ctrl  final MISR value of last test
//   repeat_flag   BIST    -> ctrl  pattern reuse detected (optional feature)
//
// Modports:
//   master - the test-control side (drives start/seed/num_pat/golden/response)
//   slave  - the BIST sequencer itself
// ---------------------------------------------------------------------------
interface prpg_bist_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);

  logic             start;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] num_pat;
  logic [WIDTH-1:0] golden;
  logic [WIDTH-1:0] response;
  logic [WIDTH-1:0] pattern;
  logic             pattern_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic             seed_err;
  logic [WIDTH-1:0] signature;
  logic             repeat_flag;

  modport master (
    output start, seed, num_pat, golden, response,
    input  pattern, pattern_valid, busy, done, pass, seed_err, signature,
           repeat_flag
  );

  modport slave (
    input  start, seed, num_pat, golden, response,
    output pattern, pattern_valid, busy, done, pass, seed_err, signature,
           repeat_flag
  );

endinterface

// File: rtl/prpg_bist_ctrl.sv
// ---------------------------------------------------------------------------
// prpg_bist_ctrl
//
// Purpose: BIST sequencer. On start it seeds a Fibonacci PRPG (shift toward
// the MSB, feedback into bit 0), streams num_pat patterns to a combinational
// CUT, folds every CUT response into a MISR, then compares the final
// signature against golden and reports pass/fail with a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; aborts a running test silently
//   bus    prpg_bist_ctrl_if.slave carrying start, seed, num_pat, golden,
//          response (in) and pattern, pattern_valid, busy, done, pass,
//          seed_err, signature, repeat_flag (out)
//
// Parameters:
//   WIDTH  PRPG / MISR / pattern width (>= 2)
//   TAPS   feedback mask; feedback bit = XOR-reduce(reg & TAPS)
//   CNT_W  width of the pattern counter and num_pat
//
// Optional feature (macro PRPG_BIST_REPEAT_CHECK_EN):
//   When defined, the seed is held for the duration of the test and
//   repeat_flag goes high (sticky until the next start) if the PRPG is about
//   to return to the seed while more patterns remain, i.e. num_pat exceeds
//   the LFSR period. When undefined, repeat_flag is tied low and no seed
//   copy is kept.
// ---------------------------------------------------------------------------
module prpg_bist_ctrl #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b101),
  parameter int               CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prpg_bist_ctrl_if.slave      bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StRun,
    StCompare,
    StDone
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] prpg_q,      prpg_d;
  logic [WIDTH-1:0] misr_q,      misr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [CNT_W-1:0] numPat_q,    numPat_d;
  logic             pass_q,      pass_d;
  logic             seedErr_q,   seedErr_d;
  logic [WIDTH-1:0] signature_q, signature_d;

  logic [WIDTH-1:0] prpgShift;
  logic             lastPattern;

  // One LFSR step shared by the PRPG and the MISR: shift toward the MSB and
  // feed the XOR of the tapped bits back into bit 0.
  function automatic logic [WIDTH-1:0] shiftReg(input logic [WIDTH-1:0] r);
    return {r[WIDTH-2:0], ^(r & TAPS)};
  endfunction

  // The PRPG's next value is needed both by the RUN datapath and by the
  // optional repeat detector, so compute it once. lastPattern uses the full
  // counter width so num_pat = 2^CNT_W-1 terminates correctly; RUN is only
  // entered with a non-zero num_pat, so the subtraction never wraps there.
  assign prpgShift   = shiftReg(prpg_q);
  assign lastPattern = (count_q == (numPat_q - CNT_W'(1)));

  // State and datapath registers. Reset is synchronous and dominates
  // everything, so a test in flight is abandoned without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prpg_q      <= WIDTH'(1);
      misr_q      <= '0;
      count_q     <= '0;
      numPat_q    <= '0;
      pass_q      <= 1'b0;
      seedErr_q   <= 1'b0;
      signature_q <= '0;
    end else begin
      state_q     <= state_d;
      prpg_q      <= prpg_d;
      misr_q      <= misr_d;
      count_q     <= count_d;
      numPat_q    <= numPat_d;
      pass_q      <= pass_d;
      seedErr_q   <= seedErr_d;
      signature_q <= signature_d;
    end
  end

  // Next-state and datapath logic. Everything holds by default; each state
  // only touches what it owns. start is looked at in IDLE only, so a start
  // while busy (including the DONE cycle) is dropped rather than queued.
  // num_pat is copied at start and seed is used only in SEED, so later
  // changes on those inputs cannot disturb a running test; golden is read
  // only in COMPARE.
  always_comb begin
    state_d     = state_q;
    prpg_d      = prpg_q;
    misr_d      = misr_q;
    count_d     = count_q;
    numPat_d    = numPat_q;
    pass_d      = pass_q;
    seedErr_d   = seedErr_q;
    signature_d = signature_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StSeed;
          numPat_d    = bus.num_pat;
          pass_d      = 1'b0;
          seedErr_d   = 1'b0;
          signature_d = '0;
        end
      end

      StSeed: begin
        prpg_d  = bus.seed;
        misr_d  = '0;
        count_d = '0;
        if (bus.seed == '0) begin
          seedErr_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = StDone;
        end else if (numPat_q == '0) begin
          state_d = StCompare;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        misr_d  = shiftReg(misr_q) ^ bus.response;
        prpg_d  = prpgShift;
        count_d = count_q + CNT_W'(1);
        if (lastPattern) begin
          state_d = StCompare;
        end
      end

      StCompare: begin
        signature_d = misr_q;
        pass_d      = (misr_q == bus.golden);
        state_d     = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs are pure decodes of the state plus the held result
  // registers, so they line up exactly with the state timeline.
  assign bus.pattern       = prpg_q;
  assign bus.pattern_valid = (state_q == StRun);
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.pass          = pass_q;
  assign bus.seed_err      = seedErr_q;
  assign bus.signature     = signature_q;

`ifdef PRPG_BIST_REPEAT_CHECK_EN

  logic [WIDTH-1:0] seedHold_q, seedHold_d;
  logic             repeat_q,   repeat_d;

  // Repeat detector. The seed is copied alongside the PRPG load so the RUN
  // state can spot the PRPG about to come back to it. The flag is only
  // raised while patterns remain after this one, so a num_pat equal to the
  // period exactly does not count as reuse.
  always_comb begin
    seedHold_d = seedHold_q;
    repeat_d   = repeat_q;
    if ((state_q == StIdle) && bus.start) begin
      repeat_d = 1'b0;
    end
    if (state_q == StSeed) begin
      seedHold_d = bus.seed;
    end
    if ((state_q == StRun) && (prpgShift == seedHold_q) &&
        (count_q < (numPat_q - CNT_W'(1)))) begin
      repeat_d = 1'b1;
    end
  end

  // Repeat detector registers, cleared by the same synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seedHold_q <= '0;
      repeat_q   <= 1'b0;
    end else begin
      seedHold_q <= seedHold_d;
      repeat_q   <= repeat_d;
    end
  end

  assign bus.repeat_flag = repeat_q;

`else

  assign bus.repeat_flag = 1'b0;

`endif

endmodule

// File: tb/tb_prpg_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prpg_bist_ctrl
//
// Directed bench for prpg_bist_ctrl (WIDTH=3, TAPS=3'b101, CNT_W=8). Every
// expected value below is worked out by hand from the LFSR shift rule and
// the state timeline (start seen at edge 0 -> SEED in cycle 1).
// Build with +define+PRPG_BIST_REPEAT_CHECK_EN to expect the repeat flag.
// ---------------------------------------------------------------------------
module tb_prpg_bist_ctrl;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic             loopback = 1'b0;
  logic [WIDTH-1:0] respVal  = '0;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [WIDTH-1:0] patLog [0:31];
  int               patCount;
  int               doneCycle;
  int               doneSeen;

  // Hand-computed PRPG stream from seed 001 with taps 101; period 7.
  logic [WIDTH-1:0] expSeq [0:8] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101,
                                     3'b010, 3'b100, 3'b001, 3'b011};

`ifdef PRPG_BIST_REPEAT_CHECK_EN
  localparam logic REPEAT_EXPECTED = 1'b1;
`else
  localparam logic REPEAT_EXPECTED = 1'b0;
`endif

  prpg_bist_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  prpg_bist_ctrl #(
    .WIDTH (WIDTH),
    .TAPS  (3'b101),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // The CUT model: either a fixed response or a straight loopback of the
  // pattern, which makes the signature easy to work out by hand.
  assign bus.response = loopback ? bus.pattern : respVal;

  always #5 clk = ~clk;

  // Count a comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a test request and let the start edge happen; returns in cycle 1.
  task automatic applyStimulus(input logic [WIDTH-1:0] seed,
                               input logic [CNT_W-1:0] numPat,
                               input logic [WIDTH-1:0] golden,
                               input logic loop);
    loopback    = loop;
    bus.seed    = seed;
    bus.num_pat = numPat;
    bus.golden  = golden;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
  endtask

  // Step through the test from cycle 1, logging applied patterns, until done
  // or the cycle budget runs out. From cycle 2 on, seed and num_pat are
  // disturbed to show they no longer matter; start can be poked at one cycle.
  task automatic runToDone(input int limit, input int pokeCycle);
    doneCycle = 0;
    patCount  = 0;
    for (int c = 1; c <= limit; c++) begin
      if (c == 2) begin
        bus.seed    = ~bus.seed;
        bus.num_pat = bus.num_pat + 8'd1;
      end
      bus.start = (c == pokeCycle);
      if (bus.pattern_valid && patCount < 32) begin
        patLog[patCount] = bus.pattern;
        patCount++;
      end
      if (bus.done) begin
        doneCycle = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  // Watch a few cycles after a test and count any further done pulses.
  task automatic watchIdle(input int cycles);
    doneSeen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) doneSeen++;
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.seed    = '0;
    bus.num_pat = '0;
    bus.golden  = '0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst pattern",   32'(bus.pattern),       32'h1);
    checkOutput("rst valid",     32'(bus.pattern_valid), 32'h0);
    checkOutput("rst busy",      32'(bus.busy),          32'h0);
    checkOutput("rst done",      32'(bus.done),          32'h0);
    checkOutput("rst pass",      32'(bus.pass),          32'h0);
    checkOutput("rst seedErr",   32'(bus.seed_err),      32'h0);
    checkOutput("rst signature", 32'(bus.signature),     32'h0);
    checkOutput("rst repeat",    32'(bus.repeat_flag),   32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-period sequence, zero response: done in cycle 10, signature 0.
    applyStimulus(3'b001, 8'd7, 3'b000, 1'b0);
    checkOutput("seq busy c1", 32'(bus.busy), 32'h1);
    runToDone(20, 0);
    checkOutput("seq doneCycle", 32'(doneCycle), 32'd10);
    checkOutput("seq patCount",  32'(patCount),  32'd7);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("seq pattern%0d", i), 32'(patLog[i]), 32'(expSeq[i]));
    end
    checkOutput("seq signature", 32'(bus.signature), 32'h0);
    checkOutput("seq pass",      32'(bus.pass),      32'h1);
    checkOutput("seq repeat",    32'(bus.repeat_flag), 32'h0);
    watchIdle(2);
    checkOutput("seq single done", 32'(doneSeen), 32'd0);
    checkOutput("seq idle busy",   32'(bus.busy), 32'h0);

    // Loopback, 3 patterns 001,011,111: MISR 001 -> 000 -> 111.
    applyStimulus(3'b001, 8'd3, 3'b111, 1'b1);
    runToDone(20, 0);
    checkOutput("loop doneCycle", 32'(doneCycle),     32'd6);
    checkOutput("loop signature", 32'(bus.signature), 32'h7);
    checkOutput("loop pass",      32'(bus.pass),      32'h1);
    watchIdle(1);

    // Same stimulus, wrong golden.
    applyStimulus(3'b001, 8'd3, 3'b110, 1'b1);
    checkOutput("loopBad cleared pass", 32'(bus.pass),      32'h0);
    checkOutput("loopBad cleared sig",  32'(bus.signature), 32'h0);
    runToDone(20, 0);
    checkOutput("loopBad signature", 32'(bus.signature), 32'h7);
    checkOutput("loopBad pass",      32'(bus.pass),      32'h0);
    watchIdle(1);

    // Zero seed: straight to DONE in cycle 2 with seed_err.
    applyStimulus(3'b000, 8'd5, 3'b000, 1'b0);
    runToDone(20, 0);
    checkOutput("zero doneCycle", 32'(doneCycle),    32'd2);
    checkOutput("zero patCount",  32'(patCount),     32'd0);
    checkOutput("zero seedErr",   32'(bus.seed_err), 32'h1);
    checkOutput("zero pass",      32'(bus.pass),     32'h0);
    watchIdle(1);
    checkOutput("zero seedErr held", 32'(bus.seed_err), 32'h1);

    // num_pat = 0: SEED -> COMPARE, done in cycle 3, signature 0 matches.
    applyStimulus(3'b101, 8'd0, 3'b000, 1'b0);
    checkOutput("np0 seedErr cleared", 32'(bus.seed_err), 32'h0);
    runToDone(20, 0);
    checkOutput("np0 doneCycle", 32'(doneCycle),     32'd3);
    checkOutput("np0 patCount",  32'(patCount),      32'd0);
    checkOutput("np0 signature", 32'(bus.signature), 32'h0);
    checkOutput("np0 pass",      32'(bus.pass),      32'h1);
    watchIdle(1);

    // start poked in RUN and in DONE is ignored; num_pat change is ignored.
    applyStimulus(3'b001, 8'd5, 3'b000, 1'b0);
    runToDone(20, 3);
    checkOutput("ign doneCycle", 32'(doneCycle), 32'd8);
    checkOutput("ign patCount",  32'(patCount),  32'd5);
    checkOutput("ign pattern4",  32'(patLog[4]), 32'(expSeq[4]));
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("ign startInDone busy", 32'(bus.busy), 32'h0);
    checkOutput("ign pass held",        32'(bus.pass), 32'h1);
    watchIdle(6);
    checkOutput("ign no extra done", 32'(doneSeen), 32'd0);
    checkOutput("ign still idle",    32'(bus.busy), 32'h0);

    // Past the period: patterns 8 and 9 repeat 001, 011.
    applyStimulus(3'b001, 8'd9, 3'b000, 1'b0);
    runToDone(30, 0);
    checkOutput("rep doneCycle", 32'(doneCycle), 32'd12);
    checkOutput("rep patCount",  32'(patCount),  32'd9);
    checkOutput("rep pattern7",  32'(patLog[7]), 32'(expSeq[7]));
    checkOutput("rep pattern8",  32'(patLog[8]), 32'(expSeq[8]));
    checkOutput("rep pass",      32'(bus.pass),  32'h1);
    checkOutput("rep flag",      32'(bus.repeat_flag), 32'(REPEAT_EXPECTED));
    watchIdle(1);
    checkOutput("rep flag held", 32'(bus.repeat_flag), 32'(REPEAT_EXPECTED));

    // Reset in the middle of RUN: back to reset values, no done pulse.
    applyStimulus(3'b011, 8'd7, 3'b000, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort running", 32'(bus.pattern_valid), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort busy",      32'(bus.busy),          32'h0);
    checkOutput("abort valid",     32'(bus.pattern_valid), 32'h0);
    checkOutput("abort pattern",   32'(bus.pattern),       32'h1);
    checkOutput("abort done",      32'(bus.done),          32'h0);
    checkOutput("abort pass",      32'(bus.pass),          32'h0);
    checkOutput("abort signature", 32'(bus.signature),     32'h0);
    checkOutput("abort repeat",    32'(bus.repeat_flag),   32'h0);
    rst_n = 1'b1;
    watchIdle(12);
    checkOutput("abort no done", 32'(doneSeen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/prpg_bist_ctrl.md
Name: prpg_bist_ctrl

Overview:
- BIST sequencer built around a Fibonacci-style PRPG (shift toward MSB; feedback into bit 0).
- On `start`, it seeds the PRPG and streams `num_pat` patterns to a combinational circuit-under-test (CUT).
- It compacts each CUT response into a MISR (multiple-input signature register), compares the final signature to `golden`, and reports pass/fail.
- Sits between the test-control logic and the CUT; it is the only driver of the pattern generator.

Parameters:
- WIDTH, 3, PRPG/MISR/pattern width (>=2).
- TAPS, 3'b101, feedback mask; feedback = XOR-reduce(reg & TAPS).
- CNT_W, 8, width of the pattern counter and `num_pat`.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a test; sampled only in IDLE
- seed  in  WIDTH  PRPG seed, captured in SEED
- num_pat  in  CNT_W  patterns to apply, captured at start
- golden  in  WIDTH  expected signature, sampled in COMPARE
- response  in  WIDTH  CUT output, sampled while pattern_valid=1
- pattern  out  WIDTH  current PRPG state driven to the CUT
- pattern_valid  out  1  high in RUN only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- pass  out  1  result of last test, held until next start
- seed_err  out  1  last seed was all-zero, held until next start
- signature  out  WIDTH  final MISR value, held until next start
- repeat_flag  out  1  see Optional Feature

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; PRPG=1; MISR=0; count=0.
  - pattern=1; pattern_valid=0, busy=0, done=0, pass=0, seed_err=0; signature=0; repeat_flag=0.
  - Reset wins over all other inputs and aborts a test mid-run with no done pulse.
- Shift rule, for both PRPG and MISR: next = {reg[WIDTH-2:0], ^(reg & TAPS)}. MISR additionally XORs in `response`.
- IDLE:
  - start=1 → SEED; num_pat latched.
  - pass, seed_err and signature are cleared on this edge.
- SEED (1 cycle):
  - PRPG<=seed; MISR<=0; count<=0.
  - seed==0 → seed_err<=1, go to DONE with pass=0.
  - Else, num_pat==0 → COMPARE.
  - Else → RUN.
- RUN:
  - pattern_valid=1 and pattern=PRPG.
  - Each edge: MISR<=shift(MISR)^response; PRPG<=shift(PRPG); count<=count+1.
  - When count==num_pat-1, the last response is absorbed on that edge → COMPARE.
  - Exactly num_pat patterns are applied; the PRPG wraps freely at its period.
- COMPARE (1 cycle): signature<=MISR; pass<=(MISR==golden) → DONE.
- DONE (1 cycle): done=1 → IDLE.
- Latency: start seen at edge 0 gives SEED in cycle 1, RUN in cycles 2..num_pat+1, COMPARE in num_pat+2, done=1 in cycle num_pat+3.
  - Zero seed: done in cycle 2.
  - num_pat=0: done in cycle 3, with signature=0.
- Boundary rules:
  - start while busy is ignored; it is not queued.
  - start in the DONE cycle is ignored.
  - `seed` and `golden` changes outside their sampling states have no effect.
  - `num_pat` changes after start have no effect.
  - count compare uses the full CNT_W bits; num_pat=2^CNT_W-1 is legal.

Optional Feature:
- Macro: PRPG_BIST_REPEAT_CHECK_EN.
- Enabled: in RUN, if the next PRPG value equals the latched seed while count<num_pat-1, repeat_flag<=1 (sticky until next start). This flags pattern reuse because num_pat exceeds the LFSR period. The test still completes normally.
- Disabled: repeat_flag is tied to 0, and no seed-holding register is synthesized beyond what SEED needs.

Test Plan:
- Reset mid-RUN: assert rst_n=0 → next cycle state IDLE, all outputs at reset values, no done pulse.
- Sequence check:
  - Stimulus: seed=3'b001, num_pat=7, response=0.
  - Required pattern stream: 001, 011, 111, 110, 101, 010, 100.
  - Required timing: done in cycle 10.
- Loopback pass:
  - Stimulus: response=pattern, seed=001, num_pat=3, golden=3'b111.
  - Required: signature=111, pass=1.
  - Repeat with golden=110 → pass=0, signature=111.
- Edge cases:
  - seed=000 → seed_err=1, pass=0, done in cycle 2, pattern_valid never high.
  - num_pat=0, golden=000 → pass=1, done in cycle 3.
- start pulsed during RUN → ignored; exactly num_pat patterns applied; a single done pulse.
- With PRPG_BIST_REPEAT_CHECK_EN: seed=001, num_pat=9 → repeat_flag=1 after the 7th pattern, test still completes.
  - Without the macro: repeat_flag stays 0.
